// File: rtl/bbox_msg_reader.sv
// Avalon-MM master that drains the image processor's bounding-box message FIFO and publishes one box per message.
// Optional processor-ID check at start-up is enabled by defining BBOX_READER_IDCHK_EN.
module bbox_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter logic [31:0] MSG_ID        = 32'h00524242,
    parameter logic [31:0] PROC_ID       = 32'h1234EEE2,
    parameter int unsigned IMAGE_W       = 640,
    parameter int unsigned IMAGE_H       = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic [10:0] bbox_left,
    output logic [10:0] bbox_top,
    output logic [10:0] bbox_right,
    output logic [10:0] bbox_bottom,
    output logic        bbox_found,
    output logic        bbox_valid,
    output logic [15:0] msg_count,
    output logic [7:0]  err_count,
    output logic        fault
);

    localparam int unsigned TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
    localparam logic [2:0]  ADDR_ID     = 3'd2;
    localparam logic [31:0] FLUSH_CMD   = 32'h0000_0010;
    localparam logic [7:0]  MSG_WORDS   = 8'd3;

    // Every RD_* is followed by a WT_* so the read strobe always has a low cycle after it;
    // the slave pops its FIFO only on a rising edge of m_read.
    typedef enum logic [3:0] {
        IDLE,
        RD_ST,
        WT_ST,
        RD_ID,
        WT_ID,
        RD_TL,
        WT_TL,
        RD_BR,
        WT_BR,
        CHECK,
        PUB,
        FLUSH
`ifdef BBOX_READER_IDCHK_EN
        ,
        INIT_RD,
        INIT_WT,
        FAULT
`endif
    } state_t;

`ifdef BBOX_READER_IDCHK_EN
    localparam state_t RESET_STATE = INIT_RD;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [31:0]     id_word;
    logic [31:0]     tl_word;
    logic [31:0]     br_word;

    logic [10:0]     tl_x;
    logic [10:0]     tl_y;
    logic [10:0]     br_x;
    logic [10:0]     br_y;
    logic            fmt_ok;
    logic            range_ok;
    logic            msg_ok;
    logic            timer_zero;
    logic [7:0]      fifo_used;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Poll timer: held at the reload value outside IDLE, counts down inside it and
    // reloads on expiry (whether or not the poll is taken).
    assign timer_zero = (timer == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= TIMER_RELOAD;
        end else if (state != IDLE || timer_zero) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    // Message words land on m_readdata the cycle after their strobe.
    // NOTE: the capture registers are reset so a message interrupted by reset never leaks old words into CHECK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_word <= '0;
            tl_word <= '0;
            br_word <= '0;
        end else begin
            if (state == WT_ID) id_word <= m_readdata;
            if (state == WT_TL) tl_word <= m_readdata;
            if (state == WT_BR) br_word <= m_readdata;
        end
    end

    // ------------------------------------------------------------------
    // Message decode and validation
    // ------------------------------------------------------------------
    assign tl_x      = tl_word[26:16];
    assign tl_y      = tl_word[10:0];
    assign br_x      = br_word[26:16];
    assign br_y      = br_word[10:0];
    assign fifo_used = m_readdata[15:8];

    assign fmt_ok   = (tl_word[31:27] == 5'd0) && (tl_word[15:11] == 5'd0) &&
                      (br_word[31:27] == 5'd0) && (br_word[15:11] == 5'd0);
    assign range_ok = (32'(tl_x) < IMAGE_W) && (32'(tl_y) < IMAGE_H) &&
                      (32'(br_x) < IMAGE_W) && (32'(br_y) < IMAGE_H);
    assign msg_ok   = (id_word == MSG_ID) && fmt_ok && range_ok;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (timer_zero && enable) state_nxt = RD_ST;
            RD_ST:   state_nxt = WT_ST;
            WT_ST:   state_nxt = (fifo_used >= MSG_WORDS) ? RD_ID : IDLE;
            RD_ID:   state_nxt = WT_ID;
            WT_ID:   state_nxt = RD_TL;
            RD_TL:   state_nxt = WT_TL;
            WT_TL:   state_nxt = RD_BR;
            RD_BR:   state_nxt = WT_BR;
            WT_BR:   state_nxt = CHECK;
            CHECK:   state_nxt = msg_ok ? PUB : FLUSH;
            PUB:     state_nxt = RD_ST;
            FLUSH:   state_nxt = IDLE;
`ifdef BBOX_READER_IDCHK_EN
            INIT_RD: state_nxt = INIT_WT;
            INIT_WT: state_nxt = (m_readdata == PROC_ID) ? IDLE : FAULT;
            FAULT:   state_nxt = FAULT;
`endif
            default: state_nxt = RESET_STATE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (bus strobes and status flags)
    // ------------------------------------------------------------------
    // NOTE: combinational blocks use blocking (=) so later lines see the values just computed.
    always_comb begin
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_address   = ADDR_STATUS;
        m_writedata = '0;
        bbox_valid  = 1'b0;
        fault       = 1'b0;
        case (state)
            RD_ST: begin
                m_read    = 1'b1;
                m_address = ADDR_STATUS;
            end
            RD_ID, RD_TL, RD_BR: begin
                m_read    = 1'b1;
                m_address = ADDR_MSG;
            end
            FLUSH: begin
                m_write     = 1'b1;
                m_address   = ADDR_STATUS;
                m_writedata = FLUSH_CMD;
            end
            PUB: bbox_valid = 1'b1;
`ifdef BBOX_READER_IDCHK_EN
            INIT_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_ID;
            end
            FAULT: fault = 1'b1;
`endif
            default: ;
        endcase
        m_chipselect = m_read | m_write;
    end

    // Box registers load as the FSM enters PUB, so they change together with the bbox_valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bbox_left   <= '0;
            bbox_top    <= '0;
            bbox_right  <= '0;
            bbox_bottom <= '0;
            bbox_found  <= 1'b0;
            msg_count   <= '0;
            err_count   <= '0;
        end else if (state == CHECK) begin
            if (msg_ok) begin
                bbox_left   <= tl_x;
                bbox_top    <= tl_y;
                bbox_right  <= br_x;
                bbox_bottom <= br_y;
                bbox_found  <= (br_x >= tl_x) && (br_y >= tl_y);
                msg_count   <= msg_count + 16'd1;
            end else if (err_count != 8'hFF) begin
                err_count   <= err_count + 8'd1;
            end
        end
    end

`ifndef BBOX_READER_IDCHK_EN
    logic unused_proc_id;
    assign unused_proc_id = ^{PROC_ID, ADDR_ID};
`endif

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Directed bench for bbox_msg_reader with a behavioural model of the message-FIFO slave.
// Define BBOX_READER_IDCHK_EN on both bench and RTL to exercise the processor-ID fault path.
module tb_bbox_msg_reader;

    localparam int unsigned P = 8;
    localparam logic [31:0] MSG_ID  = 32'h00524242;
    localparam logic [31:0] PROC_ID = 32'h1234EEE2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic [10:0] bbox_left;
    logic [10:0] bbox_top;
    logic [10:0] bbox_right;
    logic [10:0] bbox_bottom;
    logic        bbox_found;
    logic        bbox_valid;
    logic [15:0] msg_count;
    logic [7:0]  err_count;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    // Slave model and bus monitor state
    logic [31:0] fifo[$];
    logic [31:0] proc_id_val   = PROC_ID;
    logic        prev_read     = 1'b0;
    int          cyc           = 0;
    int          rd_total      = 0;
    int          wr_total      = 0;
    int          st_reads      = 0;
    int          msg_reads     = 0;
    int          valid_total   = 0;
    int          adj_viol      = 0;
    int          cs_viol       = 0;
    int          st_prev_cyc   = 0;
    int          st_last_cyc   = 0;
    int          valid_last_cyc = 0;
    logic [2:0]  last_wr_addr  = '0;
    logic [31:0] last_wr_data  = '0;

    bbox_msg_reader #(
        .POLL_INTERVAL (P),
        .MSG_ID        (MSG_ID),
        .PROC_ID       (PROC_ID),
        .IMAGE_W       (640),
        .IMAGE_H       (480)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .bbox_left    (bbox_left),
        .bbox_top     (bbox_top),
        .bbox_right   (bbox_right),
        .bbox_bottom  (bbox_bottom),
        .bbox_found   (bbox_found),
        .bbox_valid   (bbox_valid),
        .msg_count    (msg_count),
        .err_count    (err_count),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Slave: status returns used<<8, message address pops on a read rising edge, latency 1.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_read <= m_read;
        if (m_chipselect !== (m_read | m_write)) cs_viol <= cs_viol + 1;
        m_readdata <= 32'h0;
        if (m_read) begin
            rd_total <= rd_total + 1;
            if (prev_read) adj_viol <= adj_viol + 1;
            case (m_address)
                3'd0: begin
                    m_readdata  <= {16'd0, 8'(fifo.size()), 8'd0};
                    st_reads    <= st_reads + 1;
                    st_prev_cyc <= st_last_cyc;
                    st_last_cyc <= cyc;
                end
                3'd1: begin
                    msg_reads <= msg_reads + 1;
                    if (!prev_read && fifo.size() > 0) m_readdata <= fifo.pop_front();
                end
                3'd2: m_readdata <= proc_id_val;
                default: ;
            endcase
        end
        if (m_write) begin
            wr_total     <= wr_total + 1;
            last_wr_addr <= m_address;
            last_wr_data <= m_writedata;
            if (m_address == 3'd0 && m_writedata == 32'h10) fifo.delete();
        end
        if (bbox_valid) begin
            valid_total    <= valid_total + 1;
            valid_last_cyc <= cyc;
        end
    end

    function automatic int ctr(input int sel);
        case (sel)
            0: return valid_total;
            1: return wr_total;
            2: return st_reads;
            default: return msg_reads;
        endcase
    endfunction

    // Wait (bounded) for a monitor counter to reach a target; ok=0 on timeout.
    task automatic wait_ctr(input int sel, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ctr(sel) >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_msg(input logic [31:0] id, input logic [31:0] tl, input logic [31:0] br);
        fifo.push_back(id);
        fifo.push_back(tl);
        fifo.push_back(br);
    endtask

    task automatic test_reset();
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0 || m_chipselect !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", m_read, m_write, m_chipselect); end
        checks++; if ({bbox_left, bbox_top, bbox_right, bbox_bottom} !== 44'd0) begin
            failures++; $display("FAIL reset_bbox got=%h exp=0", {bbox_left, bbox_top, bbox_right, bbox_bottom}); end
        checks++; if (bbox_found !== 1'b0 || bbox_valid !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b exp=00", bbox_found, bbox_valid); end
        checks++; if (msg_count !== 16'd0 || err_count !== 8'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", msg_count, err_count); end
        checks++; if (fault !== 1'b0) begin
            failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    endtask

    task automatic test_single();
        bit ok;
        int v0;
        v0 = valid_total;
        push_msg(MSG_ID, 32'h00640032, 32'h00C80096);
        enable = 1'b1;
        wait_ctr(0, v0 + 1, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=none exp=bbox_valid"); end
        checks++; if (bbox_left !== 11'd100 || bbox_top !== 11'd50) begin
            failures++; $display("FAIL single_tl got=%0d,%0d exp=100,50", bbox_left, bbox_top); end
        checks++; if (bbox_right !== 11'd200 || bbox_bottom !== 11'd150) begin
            failures++; $display("FAIL single_br got=%0d,%0d exp=200,150", bbox_right, bbox_bottom); end
        checks++; if (bbox_found !== 1'b1 || msg_count !== 16'd1) begin
            failures++; $display("FAIL single_found_count got=%b/%0d exp=1/1", bbox_found, msg_count); end
        checks++; if (bbox_valid !== 1'b0) begin
            failures++; $display("FAIL single_pulse_width got=%b exp=0", bbox_valid); end
        repeat (20) @(negedge clk);
        checks++; if (valid_total !== v0 + 1 || bbox_left !== 11'd100) begin
            failures++; $display("FAIL single_hold got=%0d pulses left=%0d exp=1 pulse left=100", valid_total - v0, bbox_left); end
    endtask

    task automatic test_empty_frame();
        bit ok;
        push_msg(MSG_ID, 32'h027F01DF, 32'h00000000);
        wait_ctr(0, valid_total + 1, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL empty_timeout got=none exp=bbox_valid"); end
        checks++; if (bbox_found !== 1'b0) begin
            failures++; $display("FAIL empty_found got=%b exp=0", bbox_found); end
        checks++; if (bbox_left !== 11'd639 || bbox_top !== 11'd479 || bbox_right !== 11'd0 || bbox_bottom !== 11'd0) begin
            failures++; $display("FAIL empty_box got=%0d,%0d,%0d,%0d exp=639,479,0,0", bbox_left, bbox_top, bbox_right, bbox_bottom); end
        checks++; if (msg_count !== 16'd2) begin
            failures++; $display("FAIL empty_count got=%0d exp=2", msg_count); end
    endtask

    task automatic test_bad_msg();
        bit ok;
        int v0, w0;
        v0 = valid_total;
        w0 = wr_total;
        push_msg(32'h00414141, 32'h00640032, 32'h00C80096);
        wait_ctr(1, w0 + 1, 100, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL badid_timeout got=none exp=flush_write"); end
        checks++; if (err_count !== 8'd1 || valid_total !== v0) begin
            failures++; $display("FAIL badid_err got=%0d pulses=%0d exp=1 pulses=0", err_count, valid_total - v0); end
        checks++; if (last_wr_addr !== 3'd0 || last_wr_data !== 32'h10 || wr_total !== w0 + 1) begin
            failures++; $display("FAIL badid_flush got=a%0d d%h n%0d exp=a0 d00000010 n1", last_wr_addr, last_wr_data, wr_total - w0); end
        checks++; if (fifo.size() !== 0) begin
            failures++; $display("FAIL badid_fifo got=%0d exp=0", fifo.size()); end
        // x = 640 is one past the frame edge
        push_msg(MSG_ID, 32'h02800000, 32'h00000000);
        wait_ctr(1, w0 + 2, 100, ok);
        checks++; if (!ok || err_count !== 8'd2) begin
            failures++; $display("FAIL range_err got=%0d exp=2", err_count); end
        // reserved bit 27 set in the TL word
        push_msg(MSG_ID, 32'h08640032, 32'h00C80096);
        wait_ctr(1, w0 + 3, 100, ok);
        checks++; if (!ok || err_count !== 8'd3 || valid_total !== v0 || msg_count !== 16'd2) begin
            failures++; $display("FAIL resv_err got=%0d/%0d exp=3/2", err_count, msg_count); end
    endtask

    task automatic test_back_to_back();
        int v0, seen, n;
        int t[3];
        logic [15:0] m0;
        enable = 1'b0;
        repeat (30) @(negedge clk);
        push_msg(MSG_ID, 32'h00010002, 32'h00030004);
        push_msg(MSG_ID, 32'h00050006, 32'h00070008);
        push_msg(MSG_ID, 32'h000A0014, 32'h01E00190);
        v0 = valid_total;
        m0 = msg_count;
        seen = v0;
        n = 0;
        enable = 1'b1;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if (valid_total > seen) begin
                t[n] = valid_last_cyc;
                n++;
                seen = valid_total;
            end
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
        // PUB -> RD_ST directly: ten states per message with no poll wait
        checks++; if (n == 3 && (t[1] - t[0] !== 10 || t[2] - t[1] !== 10)) begin
            failures++; $display("FAIL b2b_gap got=%0d,%0d exp=10,10", t[1] - t[0], t[2] - t[1]); end
        checks++; if (bbox_left !== 11'd10 || bbox_top !== 11'd20 || bbox_right !== 11'd480 || bbox_bottom !== 11'd400) begin
            failures++; $display("FAIL b2b_last got=%0d,%0d,%0d,%0d exp=10,20,480,400", bbox_left, bbox_top, bbox_right, bbox_bottom); end
        checks++; if (msg_count !== m0 + 16'd3) begin
            failures++; $display("FAIL b2b_msgcount got=%0d exp=%0d", msg_count, m0 + 16'd3); end
    endtask

    task automatic test_poll_gap();
        bit ok;
        int s0, m0, r0, w0;
        repeat (20) @(negedge clk);
        s0 = st_reads;
        m0 = msg_reads;
        fifo.push_back(MSG_ID);
        fifo.push_back(32'h0);
        wait_ctr(2, s0 + 2, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL poll_timeout got=none exp=two_status_reads"); end
        // P idle cycles plus the RD_ST/WT_ST pair between status strobes
        checks++; if (st_last_cyc - st_prev_cyc !== int'(P) + 2) begin
            failures++; $display("FAIL poll_gap got=%0d exp=%0d", st_last_cyc - st_prev_cyc, P + 2); end
        checks++; if (msg_reads !== m0) begin
            failures++; $display("FAIL poll_noread got=%0d exp=0", msg_reads - m0); end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        r0 = rd_total;
        w0 = wr_total;
        repeat (60) @(negedge clk);
        checks++; if (rd_total !== r0 || wr_total !== w0) begin
            failures++; $display("FAIL disabled_quiet got=%0d strobes exp=0", rd_total - r0 + wr_total - w0); end
        fifo.delete();
    endtask

    task automatic test_reset_midmsg();
        bit ok;
        int m0, w0;
        m0 = msg_reads;
        push_msg(MSG_ID, 32'h00640032, 32'h00C80096);
        enable = 1'b1;
        wait_ctr(3, m0 + 2, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=none exp=tl_read"); end
        reset_n = 1'b0;
        #1;
        checks++; if (m_read !== 1'b0 || m_chipselect !== 1'b0) begin
            failures++; $display("FAIL rstmid_strobe got=%b%b exp=00", m_read, m_chipselect); end
        @(negedge clk);
        checks++; if ({bbox_left, bbox_top, bbox_right, bbox_bottom, bbox_found, bbox_valid} !== 46'd0 ||
                      msg_count !== 16'd0 || err_count !== 8'd0) begin
            failures++; $display("FAIL rstmid_outputs got=%0d/%0d/%0d exp=0/0/0", bbox_left, msg_count, err_count); end
        checks++; if (fifo.size() !== 1) begin
            failures++; $display("FAIL rstmid_fifo got=%0d exp=1", fifo.size()); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        w0 = wr_total;
        push_msg(MSG_ID, 32'h00640032, 32'h00C80096);
        wait_ctr(1, w0 + 1, 100, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || err_count !== 8'd1 || fifo.size() !== 0) begin
            failures++; $display("FAIL rstmid_resync got=err%0d fifo%0d exp=err1 fifo0", err_count, fifo.size()); end
        push_msg(MSG_ID, 32'h000A0014, 32'h01E00190);
        wait_ctr(0, valid_total + 1, 100, ok);
        checks++; if (!ok || msg_count !== 16'd1 || bbox_left !== 11'd10 || bbox_bottom !== 11'd400) begin
            failures++; $display("FAIL rstmid_recover got=cnt%0d left%0d bot%0d exp=cnt1 left10 bot400", msg_count, bbox_left, bbox_bottom); end
    endtask

    task automatic test_fault();
`ifdef BBOX_READER_IDCHK_EN
        int r0, w0;
        enable = 1'b0;
        proc_id_val = 32'hDEADBEEF;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (fault !== 1'b1) begin
            failures++; $display("FAIL fault_set got=%b exp=1", fault); end
        r0 = rd_total;
        w0 = wr_total;
        enable = 1'b1;
        push_msg(MSG_ID, 32'h00640032, 32'h00C80096);
        repeat (50) @(negedge clk);
        checks++; if (rd_total !== r0 || wr_total !== w0 || fault !== 1'b1) begin
            failures++; $display("FAIL fault_quiet got=%0d strobes fault=%b exp=0 strobes fault=1", rd_total - r0 + wr_total - w0, fault); end
`else
        checks++; if (fault !== 1'b0) begin
            failures++; $display("FAIL fault_tied got=%b exp=0", fault); end
`endif
    endtask

    task automatic test_bus_rules();
        checks++; if (adj_viol !== 0) begin
            failures++; $display("FAIL read_spacing got=%0d adjacent exp=0", adj_viol); end
        checks++; if (cs_viol !== 0) begin
            failures++; $display("FAIL chipselect got=%0d bad cycles exp=0", cs_viol); end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        test_single();
        test_empty_frame();
        test_bad_msg();
        test_back_to_back();
        test_poll_gap();
        test_reset_midmsg();
        test_bus_rules();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
